// File: rtl/mem_responder_512x8.sv
// mem_responder_512x8
// Wait-state memory responder for the MOV/MOC bus handshake. It holds a
// big-endian, byte-addressed array and decodes the MIPS load/store opcode
// to size each access and to sign- or zero-extend loaded data.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset (array contents are kept)
//   MOV      operation valid; held high by the initiator until MOC is seen
//   RW       1 = load, 0 = store
//   Address  byte address, captured when a request is accepted
//   DataIn   right-justified store data, captured when a request is accepted
//   OpC      MIPS opcode, captured when a request is accepted
//   DataOut  load result, valid while MOC = 1
//   MOC      memory operation complete
//   ERR      access fault flag, valid while MOC = 1
//
// Build option: define MISALIGN_TRAP_EN to fault misaligned halfword/word
// accesses. Without it, the low address bits are cleared instead.
module mem_responder_512x8 #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    input  logic [5:0]        OpC,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              ERR
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [5:0]        opc_q, opc_d;
    logic              rw_q, rw_d;
    logic [31:0]       dout_q, dout_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;

    logic [7:0]        mem_q [DEPTH];

    logic              known_s, is_load_s, is_store_s, sign_s, misalign_s, fault_s;
    logic [1:0]        size_s;
    logic [ADDR_W-1:0] a_eff_s, a0_s, a1_s, a2_s, a3_s;
    logic [7:0]        b0_s, b1_s, b2_s, b3_s;
    logic [7:0]        wd0_s, wd1_s, wd2_s, wd3_s;
    logic [3:0]        we_s;
    logic [31:0]       load_s;

    // State register plus captured request and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            din_q   <= 32'd0;
            opc_q   <= 6'd0;
            rw_q    <= 1'b0;
            dout_q  <= 32'd0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            opc_q   <= opc_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
    end

    // Array write port; suppressed during reset so an aborted store never lands
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (we_s[0]) mem_q[a0_s] <= wd0_s;
            if (we_s[1]) mem_q[a1_s] <= wd1_s;
            if (we_s[2]) mem_q[a2_s] <= wd2_s;
            if (we_s[3]) mem_q[a3_s] <= wd3_s;
        end
    end

    // Next-state logic: accept, wait, abort on MOV drop, commit, handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        opc_d   = opc_q;
        rw_d    = rw_q;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    addr_d  = Address;
                    din_d   = DataIn;
                    opc_d   = OpC;
                    rw_d    = RW;
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_LD == 4'd0) ? S_COMMIT : S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!MOV) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    // Decremented value reaching zero ends the wait
                    state_d = (cnt_q <= 4'd1) ? S_COMMIT : S_BUSY;
                end
            end
            S_COMMIT: state_d = S_DONE;
            S_DONE: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Opcode decode into direction, size and extension
    always_comb begin
        known_s    = 1'b1;
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        sign_s     = 1'b0;
        size_s     = SZ_BYTE;
        case (opc_q)
            OP_LB:   begin is_load_s = 1'b1;  sign_s = 1'b1; size_s = SZ_BYTE; end
            OP_LBU:  begin is_load_s = 1'b1;                 size_s = SZ_BYTE; end
            OP_LH:   begin is_load_s = 1'b1;  sign_s = 1'b1; size_s = SZ_HALF; end
            OP_LHU:  begin is_load_s = 1'b1;                 size_s = SZ_HALF; end
            OP_LW:   begin is_load_s = 1'b1;                 size_s = SZ_WORD; end
            OP_SB:   begin is_store_s = 1'b1;                size_s = SZ_BYTE; end
            OP_SH:   begin is_store_s = 1'b1;                size_s = SZ_HALF; end
            OP_SW:   begin is_store_s = 1'b1;                size_s = SZ_WORD; end
            default: known_s = 1'b0;
        endcase
    end

    // Effective address, alignment handling and big-endian byte lanes
    always_comb begin
        a_eff_s    = addr_q;
        misalign_s = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (size_s == SZ_HALF) begin
            misalign_s = addr_q[0];
        end else if (size_s == SZ_WORD) begin
            misalign_s = (addr_q[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
`else
        if (size_s == SZ_HALF) begin
            a_eff_s[0] = 1'b0;
        end else if (size_s == SZ_WORD) begin
            a_eff_s[1:0] = 2'b00;
        end else begin
            a_eff_s = addr_q;
        end
`endif
        a0_s = a_eff_s;
        a1_s = a_eff_s + ADDR_W'(2'd1);
        a2_s = a_eff_s + ADDR_W'(2'd2);
        a3_s = a_eff_s + ADDR_W'(2'd3);
        b0_s = mem_q[a0_s];
        b1_s = mem_q[a1_s];
        b2_s = mem_q[a2_s];
        b3_s = mem_q[a3_s];
        fault_s = !known_s || (is_load_s && !rw_q) || (is_store_s && rw_q) || misalign_s;
    end

    // Output logic: commit result, store lanes and MOC handshake
    always_comb begin
        dout_d = dout_q;
        err_d  = err_q;
        moc_d  = moc_q;
        we_s   = 4'b0000;
        wd0_s  = 8'd0;
        wd1_s  = 8'd0;
        wd2_s  = 8'd0;
        wd3_s  = 8'd0;
        load_s = 32'd0;
        case (size_s)
            SZ_BYTE: load_s = sign_s ? {{24{b0_s[7]}}, b0_s} : {24'd0, b0_s};
            SZ_HALF: load_s = sign_s ? {{16{b0_s[7]}}, b0_s, b1_s} : {16'd0, b0_s, b1_s};
            SZ_WORD: load_s = {b0_s, b1_s, b2_s, b3_s};
            default: load_s = 32'd0;
        endcase
        case (state_q)
            S_IDLE: moc_d = 1'b0;
            S_BUSY: moc_d = 1'b0;
            S_COMMIT: begin
                moc_d = 1'b1;
                if (fault_s) begin
                    err_d  = 1'b1;
                    dout_d = 32'd0;
                end else if (is_load_s) begin
                    err_d  = 1'b0;
                    dout_d = load_s;
                end else begin
                    err_d  = 1'b0;
                    dout_d = 32'd0;
                    case (size_s)
                        SZ_BYTE: begin we_s = 4'b0001; wd0_s = din_q[7:0]; end
                        SZ_HALF: begin
                            we_s  = 4'b0011;
                            wd0_s = din_q[15:8];
                            wd1_s = din_q[7:0];
                        end
                        SZ_WORD: begin
                            we_s  = 4'b1111;
                            wd0_s = din_q[31:24];
                            wd1_s = din_q[23:16];
                            wd2_s = din_q[15:8];
                            wd3_s = din_q[7:0];
                        end
                        default: we_s = 4'b0000;
                    endcase
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    moc_d = 1'b0;
                end else begin
                    moc_d = 1'b1;
                end
            end
            default: moc_d = 1'b0;
        endcase
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_mem_responder_512x8.sv
// Directed testbench for mem_responder_512x8. Instance u_dut0 uses the
// default two wait cycles; u_dut1 uses zero wait cycles.
module tb_mem_responder_512x8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mov_s;
    logic        sel;
    logic        rw;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [5:0]  opc;
    logic [31:0] dout0, dout1;
    logic        moc0, moc1, err0, err1;
    logic        mov0, mov1;
    logic [31:0] cur_dout;
    logic        cur_moc, cur_err;

    int n_checks = 0;
    int n_fail   = 0;

    assign mov0     = mov_s & ~sel;
    assign mov1     = mov_s & sel;
    assign cur_dout = sel ? dout1 : dout0;
    assign cur_moc  = sel ? moc1 : moc0;
    assign cur_err  = sel ? err1 : err0;

    always #5 clk = ~clk;

    mem_responder_512x8 #(.WAIT_CYCLES(2), .ADDR_W(9)) u_dut0 (
        .clk(clk), .reset(reset), .MOV(mov0), .RW(rw), .Address(addr),
        .DataIn(din), .OpC(opc), .DataOut(dout0), .MOC(moc0), .ERR(err0)
    );

    mem_responder_512x8 #(.WAIT_CYCLES(0), .ADDR_W(9)) u_dut1 (
        .clk(clk), .reset(reset), .MOV(mov1), .RW(rw), .Address(addr),
        .DataIn(din), .OpC(opc), .DataOut(dout1), .MOC(moc1), .ERR(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full handshake; called on a negedge, returns on a negedge.
    // Latency counts the MOV-sampling edge as edge 1.
    task automatic access(input string tag, input logic r, input logic [5:0] op,
                          input logic [8:0] a, input logic [31:0] d,
                          input logic [31:0] exp_dout, input logic exp_err,
                          input int exp_lat, input int hold);
        int lat;
        rw = r; opc = op; addr = a; din = d; mov_s = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (cur_moc) break;
        end
        check({tag, "_moc"}, {31'd0, cur_moc}, 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_dout"}, cur_dout, exp_dout);
        check({tag, "_err"}, {31'd0, cur_err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_moc"}, {31'd0, cur_moc}, 32'd1);
            check({tag, "_hold_dout"}, cur_dout, exp_dout);
        end
        @(negedge clk);
        mov_s = 1'b0;
        @(posedge clk); #1;
        check({tag, "_mocdrop"}, {31'd0, cur_moc}, 32'd0);
        check({tag, "_douthold"}, cur_dout, exp_dout);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        reset = 1'b1; mov_s = 1'b0; sel = 1'b0; rw = 1'b0;
        addr = 9'd0; din = 32'd0; opc = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_moc", {31'd0, moc0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        check("rst_dout", dout0, 32'd0);

        // Word store/load and sub-word loads (big-endian)
        access("sw4",  1'b0, 6'b101011, 9'h004, 32'hDEADBEEF, 32'h0,        1'b0, 4, 0);
        access("lw4",  1'b1, 6'b100011, 9'h004, 32'h0,        32'hDEADBEEF, 1'b0, 4, 0);
        access("lb4",  1'b1, 6'b100000, 9'h004, 32'h0,        32'hFFFFFFDE, 1'b0, 4, 0);
        access("lbu5", 1'b1, 6'b100100, 9'h005, 32'h0,        32'h000000AD, 1'b0, 4, 0);
        access("lh6",  1'b1, 6'b100001, 9'h006, 32'h0,        32'hFFFFBEEF, 1'b0, 4, 0);
        access("lhu4", 1'b1, 6'b100101, 9'h004, 32'h0,        32'h0000DEAD, 1'b0, 4, 0);

        // Top of the array: byte store into the last location
        access("sw1fc", 1'b0, 6'b101011, 9'h1FC, 32'hA1B2C3D4, 32'h0,        1'b0, 4, 0);
        access("sb1ff", 1'b0, 6'b101000, 9'h1FF, 32'h12345680, 32'h0,        1'b0, 4, 0);
        access("lw1fc", 1'b1, 6'b100011, 9'h1FC, 32'h0,        32'hA1B2C380, 1'b0, 4, 0);
`ifdef MISALIGN_TRAP_EN
        access("lw1fd", 1'b1, 6'b100011, 9'h1FD, 32'h0,        32'h0,        1'b1, 4, 0);
        access("sh1fd", 1'b0, 6'b101001, 9'h1FD, 32'h0000FFFF, 32'h0,        1'b1, 4, 0);
        access("lw1fc2",1'b1, 6'b100011, 9'h1FC, 32'h0,        32'hA1B2C380, 1'b0, 4, 0);
`else
        access("lw1fd", 1'b1, 6'b100011, 9'h1FD, 32'h0,        32'hA1B2C380, 1'b0, 4, 0);
        access("lh1ff", 1'b1, 6'b100001, 9'h1FF, 32'h0,        32'hFFFFC380, 1'b0, 4, 0);
`endif

        // MOV held five cycles after MOC
        access("hold", 1'b1, 6'b100011, 9'h004, 32'h0, 32'hDEADBEEF, 1'b0, 4, 5);

        // Reset pulsed during BUSY aborts the store
        access("sw10", 1'b0, 6'b101011, 9'h010, 32'h01020304, 32'h0, 1'b0, 4, 0);
        rw = 1'b0; opc = 6'b101011; addr = 9'h010; din = 32'h11111111; mov_s = 1'b1;
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (moc0) seen = 1; end
        @(negedge clk);
        reset = 1'b1; mov_s = 1'b0;
        @(posedge clk); #1;
        if (moc0) seen = 1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (moc0) seen = 1; end
        check("rstabort_moc", 32'(seen), 32'd0);
        @(negedge clk);
        access("lw10a", 1'b1, 6'b100011, 9'h010, 32'h0, 32'h01020304, 1'b0, 4, 0);

        // MOV dropped during BUSY aborts the store
        rw = 1'b0; opc = 6'b101011; addr = 9'h010; din = 32'h22222222; mov_s = 1'b1;
        seen = 0;
        @(posedge clk); #1;
        @(negedge clk);
        mov_s = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (moc0) seen = 1; end
        check("movabort_moc", 32'(seen), 32'd0);
        @(negedge clk);
        access("lw10b", 1'b1, 6'b100011, 9'h010, 32'h0, 32'h01020304, 1'b0, 4, 0);

        // Faults: unknown opcode and direction mismatch (no write)
        access("op3f",  1'b1, 6'h3F,     9'h004, 32'h0,        32'h0, 1'b1, 4, 0);
        access("swrd",  1'b1, 6'b101011, 9'h004, 32'h55555555, 32'h0, 1'b1, 4, 0);
        access("lw4b",  1'b1, 6'b100011, 9'h004, 32'h0, 32'hDEADBEEF, 1'b0, 4, 0);

        // Zero wait cycles
        sel = 1'b1;
        @(negedge clk);
        access("op3f_w0", 1'b1, 6'h3F,     9'h000, 32'h0,        32'h0,        1'b1, 2, 0);
        access("sw_w0",   1'b0, 6'b101011, 9'h020, 32'hCAFEF00D, 32'h0,        1'b0, 2, 0);
        access("lw_w0",   1'b1, 6'b100011, 9'h020, 32'h0,        32'hCAFEF00D, 1'b0, 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder_512x8.md
Name: mem_responder_512x8

Overview:
Clocked, wait-state memory responder: the memory end of the datapath's MOV/MOC bus handshake.
- Backs a 512-byte, big-endian, byte-addressed array.
- Decodes the MIPS load/store opcode on OpC to size each access and sign- or zero-extend it.
- Asserts MOC after a programmable latency.
- Replaces the untimed RAM model in system sims so that datapath wait-state handling is exercised.

Parameters:
WAIT_CYCLES, 2, cycles spent in BUSY before the access commits; legal range 0..15.
ADDR_W, 9, byte-address width; array depth is 2**ADDR_W bytes.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
MOV  input  1  memory operation valid from the initiator; held high until MOC is seen.
RW  input  1  1 = read (load), 0 = write (store).
Address  input  ADDR_W  byte address, sampled on MOV rise.
DataIn  input  32  store data, right-justified, sampled on MOV rise.
OpC  input  6  MIPS opcode, sampled on MOV rise.
DataOut  output  32  load result; valid while MOC = 1.
MOC  output  1  memory operation complete.
ERR  output  1  access faulted; valid while MOC = 1.

Behaviour:
- Reset: MOC=0, ERR=0, DataOut=0, FSM=IDLE, wait counter=0. Array contents are not cleared.
- Reset mid-operation: access aborted. A store not yet committed is never written.
- IDLE:
  - On MOV=1, capture Address, DataIn, OpC and RW.
  - Load the counter with WAIT_CYCLES, then go to BUSY.
  - If WAIT_CYCLES=0, go straight to COMMIT.
- BUSY: decrement the counter each cycle. At 0, go to COMMIT.
- COMMIT (one cycle):
  - Perform the array read or write.
  - Drive DataOut and ERR registered.
  - Set MOC=1 at the end of this cycle, then go to DONE.
  - Latency from the MOV-sampling edge to MOC high is WAIT_CYCLES+2 edges.
- DONE:
  - Hold MOC, DataOut and ERR stable while MOV=1.
  - When MOV=0 is sampled, clear MOC and return to IDLE next edge.
  - DataOut holds its last value until the next COMMIT.
- MOV dropping before COMMIT: treated as abort. Return to IDLE, no write, MOC never asserted.
- Back-to-back requests: a new request is accepted only from IDLE. MOV must be low for at least one edge between requests.
- Opcode decode. Byte order is big-endian: Mem[a] is the MSB of the word at a.
  - 100000 LB: sign-extend Mem[a].
  - 100100 LBU: zero-extend Mem[a].
  - 100001 LH: sign-extend {Mem[a], Mem[a+1]}.
  - 100101 LHU: zero-extend {Mem[a], Mem[a+1]}.
  - 100011 LW: {Mem[a..a+3]}.
  - 101000 SB: Mem[a] = DataIn[7:0].
  - 101001 SH: store DataIn[15:0].
  - 101011 SW: store DataIn[31:0].
- Stores: DataOut=0 at COMMIT.
- RW/OpC mismatch (load opcode with RW=0 or vice versa): ERR=1, no write, DataOut=0, MOC still asserted.
- Unrecognised opcode: ERR=1, no array access, DataOut=0, MOC still asserted.
- Address wrap: a+1..a+3 computed modulo 2**ADDR_W, unless masked by alignment (see Optional Feature).

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Halfword with a[0]=1 → ERR=1.
  - Word with a[1:0]≠0 → ERR=1.
  - No write, DataOut=0, MOC asserted normally.
- Undefined:
  - Low bits are forced to zero: a[0] for halfwords, a[1:0] for words.
  - Access proceeds, ERR stays 0 for aligned/decoded cases, no modulo wrap occurs.

Test Plan:
- Reset held 2 cycles, then SW a=0x004 DataIn=0xDEADBEEF, then LW a=0x004 → MOC rises 4 edges after MOV sample (WAIT_CYCLES=2); DataOut=0xDEADBEEF, ERR=0.
- After that store: LB a=0x004 → 0xFFFFFFDE; LBU a=0x005 → 0x000000AD; LH a=0x006 → 0xFFFFBEEF; LHU a=0x004 → 0x0000DEAD.
- SB a=0x1FF DataIn=0x12345680 then LW a=0x1FC:
  - With MISALIGN_TRAP_EN: LW a=0x1FD → ERR=1, no write.
  - Without it: LW a=0x1FD returns the word at 0x1FC.
- MOV held high 5 cycles after MOC → MOC, DataOut stable throughout; MOC low one edge after MOV low.
- SW a=0x010 DataIn=0x11111111 with reset pulsed during BUSY → MOC never rises; subsequent LW a=0x010 returns the pre-store value.
- OpC=0x3F with RW=1 → MOC asserted, ERR=1, DataOut=0. Repeat with WAIT_CYCLES=0 → MOC 2 edges after MOV sample.
